edge_rate_meter: RTL and testbench

//  Measures the rate of a slow or asynchronous square-wave input by counting its rising edges

---
 rtl/edge_rate_meter_pkg.sv | 13 +
 rtl/edge_rate_meter_sync.sv | 27 ++
 rtl/edge_rate_meter.sv | 106 ++++++++++
 tb/tb_edge_rate_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_rate_meter_pkg.sv
// Shared definitions for the edge-rate measurement path: FSM encoding and
// synchronizer depth.
package edge_rate_meter_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/edge_rate_meter_sync.sv
// Brings an asynchronous level into the clk domain and emits a one-cycle
// pulse on each synchronized rising transition.
module sync_edge_detect
   import edge_rate_meter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_dly  <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/edge_rate_meter.sv
// Counts synchronized rising edges of sig_in over a fixed window of
// GATE_CYCLES clk cycles and reports the latched result with a valid strobe.
module edge_rate_meter
   import edge_rate_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 256,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   input  logic             continuous,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             busy,
   output logic             overflow
);

   localparam int               TMR_W    = $clog2(GATE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           r_state;
   logic [TMR_W-1:0] r_tmr;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_count;
   logic             r_valid;
   logic             r_busy;
   logic             r_ovf;

   logic             w_edge;
   logic             w_sat;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_ovf_next;

   sync_edge_detect u_sync (
      .clk    (clk),
      .rst_n  (reset),
      .i_sig  (sig_in),
      .o_rise (w_edge)
   );

   // An edge arriving with the counter already at max is the overflow event.
   assign w_sat      = w_edge && (r_cnt == CNT_MAX);
   assign w_cnt_next = (w_edge && !w_sat) ? r_cnt + 1'b1 : r_cnt;
   assign w_ovf_next = r_ovf | w_sat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_cnt   <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_GATE;
                  r_busy  <= 1'b1;
                  r_tmr   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            ST_GATE: begin
               r_cnt <= w_cnt_next;
               r_ovf <= w_ovf_next;
               // The final window cycle's edge is folded into the latched result.
               if (r_tmr == TMR_LAST) begin
                  r_state <= ST_DONE;
                  r_count <= w_cnt_next;
                  r_valid <= 1'b1;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            ST_DONE: begin
               if (continuous) begin
                  r_state <= ST_GATE;
                  r_tmr   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign count    = r_count;
   assign valid    = r_valid;
   assign busy     = r_busy;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_edge_rate_meter.sv
// Directed and randomized bench for edge_rate_meter; two instances share the
// stimulus, one with a narrow counter so saturation is exercised.
module tb_edge_rate_meter;

   localparam int G     = 16;
   localparam int W_OVF = 2;
   localparam int MAX2  = (1 << W_OVF) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sig_in = 1'b0;
   logic start = 1'b0;
   logic continuous = 1'b0;

   logic [15:0]      count;
   logic             valid, busy, overflow;
   logic [W_OVF-1:0] count2;
   logic             valid2, busy2, overflow2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic hist [0:19999];

   int mode = 0;
   int period = 4;
   int phase = 0;
   int hold = 0;

   edge_rate_meter #(.GATE_CYCLES(G), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
      .continuous(continuous), .count(count), .valid(valid),
      .busy(busy), .overflow(overflow)
   );

   edge_rate_meter #(.GATE_CYCLES(G), .CNT_W(W_OVF)) u_ovf (
      .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
      .continuous(continuous), .count(count2), .valid(valid2),
      .busy(busy2), .overflow(overflow2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      hist[cyc] <= sig_in;
      cyc       <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and update sig_in from the divider/random source.
   task automatic tick();
      @(negedge clk);
      case (mode)
         0: sig_in = 1'b0;
         1: begin
            sig_in = (phase < period / 2);
            phase  = (phase + 1) % period;
         end
         2: begin
            if (hold == 0) begin
               sig_in = ~sig_in;
               hold   = $urandom_range(1, 4);
            end
            hold--;
         end
         default: sig_in = 1'b1;
      endcase
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Edges seen by the window armed at posedge k0: the sampled signal rises,
   // and the counter sees it two samples later, over G consecutive cycles.
   function automatic int raw_edges(input int k0);
      int n = 0;
      for (int j = k0 + 1; j <= k0 + G; j++)
         if (hist[j-2] === 1'b1 && hist[j-3] === 1'b0) n++;
      return n;
   endfunction

   task automatic arm(output int k0);
      start = 1'b1;
      k0    = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int k0, input string tag);
      int  target;
      int  n;
      bit  early;
      target = k0 + G + 1;
      early  = 1'b0;
      while (cyc < target) begin
         tick();
         if (cyc < target && valid) early = 1'b1;
      end
      n = raw_edges(k0);
      check({tag, "_early_valid"}, early, 0);
      check({tag, "_valid"}, valid, 1);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_count"}, count, n);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_count_narrow"}, count2, (n > MAX2) ? MAX2 : n);
      check({tag, "_overflow_narrow"}, overflow2, (n > MAX2) ? 1 : 0);
      $display("window %s k0=%0d edges=%0d count=%0d count_narrow=%0d ovf_narrow=%0d",
               tag, k0, n, count, count2, overflow2);
   endtask

   task automatic expect_quiet(input int n, input string tag);
      int seen = 0;
      repeat (n) begin
         tick();
         if (valid) seen++;
      end
      check({tag, "_no_valid"}, seen, 0);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      int k0;
      int k;
      logic [15:0] held;

      // Reset values
      ticks(3);
      check("rst_count", count, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b1;
      ticks(5);

      // Single window, period-4 input: 4 edges, narrow counter saturates
      mode = 1; period = 4; phase = 0;
      ticks(8);
      arm(k0);
      wait_valid(k0, "t1");
      check("t1_count_const", count, 4);
      check("t1_narrow_sat", count2, 3);
      check("t1_narrow_ovf", overflow2, 1);
      held = count;
      tick();
      check("t1_after_valid", valid, 0);
      check("t1_after_busy", busy, 0);
      ticks(10);
      check("t1_count_hold", count, held);

      // Continuous windows back to back, stop re-arming mid third window
      period = 8; phase = 0;
      continuous = 1'b1;
      arm(k);
      for (int w = 0; w < 3; w++) begin
         wait_valid(k, $sformatf("t2_w%0d", w));
         k += G + 1;
         if (w == 1) begin
            tick();
            continuous = 1'b0;
         end
      end
      expect_quiet(30, "t2");

      // Randomized input including 1-cycle glitches, continuous windows
      mode = 2; hold = 0;
      continuous = 1'b1;
      arm(k);
      for (int w = 0; w < 5; w++) begin
         wait_valid(k, $sformatf("t3_rand%0d", w));
         k += G + 1;
         if (w == 3) begin
            tick();
            continuous = 1'b0;
         end
      end
      expect_quiet(10, "t3");

      // Static input after saturation: result and overflow both clear
      mode = 0;
      ticks(5);
      arm(k0);
      wait_valid(k0, "t3_static");
      check("t3_static_count", count, 0);
      check("t3_static_ovf_narrow", overflow2, 0);

      // Asynchronous reset mid-window aborts immediately
      mode = 1; period = 4; phase = 0;
      ticks(6);
      arm(k0);
      ticks(8);
      reset = 1'b0;
      #1;
      check("t4_busy", busy, 0);
      check("t4_valid", valid, 0);
      check("t4_count", count, 0);
      check("t4_overflow", overflow, 0);
      check("t4_overflow_narrow", overflow2, 0);
      tick();
      reset = 1'b1;
      expect_quiet(40, "t4");
      check("t4_count_after", count, 0);

      // Start held high: windows repeat with one IDLE cycle between them
      start = 1'b1;
      k0 = cyc;
      wait_valid(k0, "t5_held0");
      wait_valid(k0 + G + 2, "t5_held1");
      start = 1'b0;
      expect_quiet(30, "t5_held");

      // Start pulses during a running window are ignored
      mode = 2; hold = 0;
      arm(k0);
      ticks(4);
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(k0, "t5_pulse");
      expect_quiet(40, "t5_pulse");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
